// File: rtl/fitness_scheduler_pkg.sv
// fitness_scheduler_pkg: state encoding and default population geometry shared with the generation controller.
package fitness_scheduler_pkg;
    localparam int POP_SIZE_DEF = 75;
    localparam int GENE_W_DEF   = 100;
    localparam int IDX_W_DEF    = 7;
    localparam int SCORE_W_DEF  = 16;
    localparam int SUM_W_DEF    = 23;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        FINISH = 3'd4
    } state_t;
endpackage

// File: rtl/fitness_scheduler_tracker.sv
// fitness_tracker: running best/sum over one pass, committed to the result outputs at pass end.
// Ports: i_clear zeroes the run values, i_update folds in (i_idx, i_score), i_commit copies run values to o_*.
module fitness_tracker
    import fitness_scheduler_pkg::*;
#(
    parameter int IDX_W   = IDX_W_DEF,
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int SUM_W   = SUM_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_update,
    input  logic               i_commit,
    input  logic [IDX_W-1:0]   i_idx,
    input  logic [SCORE_W-1:0] i_score,
    output logic [IDX_W-1:0]   o_best_idx,
    output logic [SCORE_W-1:0] o_best_score,
    output logic [SUM_W-1:0]   o_sum
);
    logic [IDX_W-1:0]   r_run_idx;
    logic [SCORE_W-1:0] r_run_score;
    logic [SUM_W-1:0]   r_run_sum;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_idx    <= '0;
            r_run_score  <= '0;
            r_run_sum    <= '0;
            o_best_idx   <= '0;
            o_best_score <= '0;
            o_sum        <= '0;
        end else begin
            if (i_clear) begin
                r_run_idx   <= '0;
                r_run_score <= '0;
                r_run_sum   <= '0;
            end else if (i_update) begin
                r_run_sum <= r_run_sum + SUM_W'(i_score);
                // strict compare keeps the lower index on ties; index 0 always seeds the run
                if (i_score > r_run_score || i_idx == '0) begin
                    r_run_score <= i_score;
                    r_run_idx   <= i_idx;
                end
            end
            if (i_commit) begin
                o_best_idx   <= r_run_idx;
                o_best_score <= r_run_score;
                o_sum        <= r_run_sum;
            end
        end
    end
endmodule

// File: rtl/fitness_scheduler.sv
// fitness_scheduler: streams every individual through one shared evaluator and reports best/total score.
// Ports: start/abort control a pass over population; eval_* is the evaluator handshake;
// busy/done report progress; best_idx/best_score/score_sum hold the last completed pass.
module fitness_scheduler
    import fitness_scheduler_pkg::*;
#(
    parameter int POP_SIZE = POP_SIZE_DEF,
    parameter int GENE_W   = GENE_W_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int SCORE_W  = SCORE_W_DEF,
    parameter int SUM_W    = SUM_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [POP_SIZE*GENE_W-1:0] population,
    output logic                       eval_start,
    output logic [GENE_W-1:0]          eval_indiv,
    output logic [IDX_W-1:0]           eval_idx,
    input  logic                       eval_done,
    input  logic [SCORE_W-1:0]         eval_score,
    output logic                       busy,
    output logic                       done,
    output logic [IDX_W-1:0]           best_idx,
    output logic [SCORE_W-1:0]         best_score,
    output logic [SUM_W-1:0]           score_sum
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(POP_SIZE - 1);
    state_t             r_state, w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [GENE_W-1:0]  w_pop [POP_SIZE];
    logic               w_accept, w_commit;
    for (genvar g = 0; g < POP_SIZE; g++) begin : g_slice
        assign w_pop[g] = population[g*GENE_W +: GENE_W];
    end
    assign w_accept = (r_state == WAIT) && eval_done && !abort;
    assign w_commit = (r_state == FINISH) && !abort;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? LOAD : IDLE;
            LOAD:    w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = eval_done ? ((r_idx == LAST) ? FINISH : LOAD) : WAIT;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (abort) w_next = IDLE;
    end
    // status outputs are registered from the next state so they line up with the state they describe;
    // done is registered from FINISH so it rises together with the freshly committed results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            eval_start <= 1'b0;
            eval_indiv <= '0;
            eval_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            r_state    <= w_next;
            eval_start <= (w_next == ISSUE);
            busy       <= (w_next != IDLE);
            done       <= w_commit;
            if (r_state == IDLE) r_idx <= '0;
            else if (w_accept && r_idx != LAST) r_idx <= r_idx + IDX_W'(1);
            if (r_state == LOAD && !abort) begin
                eval_indiv <= w_pop[r_idx];
                eval_idx   <= r_idx;
            end
        end
    end
    fitness_tracker #(
        .IDX_W   (IDX_W),
        .SCORE_W (SCORE_W),
        .SUM_W   (SUM_W)
    ) u_tracker (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (r_state == IDLE),
        .i_update     (w_accept),
        .i_commit     (w_commit),
        .i_idx        (r_idx),
        .i_score      (eval_score),
        .o_best_idx   (best_idx),
        .o_best_score (best_score),
        .o_sum        (score_sum)
    );
endmodule

// File: doc/fitness_scheduler.md
Name: fitness_scheduler

Overview:
- Sequences one shared fitness evaluator across every individual of the current population.
- Sits between the generation state controller and the fitness unit. The controller pulses start after init or mutate completes. The scheduler streams each individual to the evaluator with a start/done handshake, tracks best and total score, then pulses done so selection can begin.

Parameters:
- POP_SIZE, 75, individuals per population
- GENE_W, 100, bits per individual
- IDX_W, 7, index width (must satisfy 2^IDX_W >= POP_SIZE)
- SCORE_W, 16, unsigned fitness score width
- SUM_W, 23, accumulator width (IDX_W+SCORE_W, cannot overflow)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to evaluate population; ignored unless IDLE
- abort  in  1  cancel current pass; returns to IDLE next cycle
- population  in  POP_SIZE*GENE_W  current population, individual i at bits [i*GENE_W +: GENE_W]; must stay stable while busy
- eval_start  out  1  one-cycle pulse to evaluator
- eval_indiv  out  GENE_W  registered individual under evaluation
- eval_idx  out  IDX_W  index of eval_indiv
- eval_done  in  1  evaluator result strobe
- eval_score  in  SCORE_W  result, valid with eval_done
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse, pass complete
- best_idx  out  IDX_W  index of highest score in the last completed pass
- best_score  out  SCORE_W  highest score in the last completed pass
- score_sum  out  SUM_W  sum of all scores in the last completed pass

Behaviour:
- Reset: state IDLE; eval_start=0, eval_indiv=0, eval_idx=0, busy=0, done=0, best_idx=0, best_score=0, score_sum=0. All working registers cleared.
- State IDLE:
  - start=1 → LOAD.
  - Cycle-local working registers cleared: idx=0, run_best_score=0, run_best_idx=0, run_sum=0.
- State LOAD:
  - eval_indiv <= slice(idx); eval_idx <= idx.
  - → ISSUE.
- State ISSUE:
  - eval_start=1 for exactly this cycle.
  - → WAIT.
- State WAIT:
  - Hold until eval_done.
  - On eval_done: run_sum += eval_score.
  - If eval_score > run_best_score, or idx==0: run_best_score <= eval_score, run_best_idx <= idx.
  - Ties keep the lower index.
  - If idx==POP_SIZE-1 → FINISH; else idx++ → LOAD.
- State FINISH:
  - best_idx/best_score/score_sum <= run values; done=1 this cycle.
  - → IDLE.
- Latency per individual: 3 cycles + evaluator latency. eval_done in the cycle immediately after eval_start is legal.
- eval_done outside WAIT is ignored. A second eval_done while in WAIT cannot occur, because state has already left WAIT.
- start while busy is ignored; no queueing.
- abort:
  - Has priority over every transition, including eval_done in the same cycle.
  - Next state IDLE; done not asserted.
  - Result outputs keep the values from the previous completed pass.
  - The evaluator is not signalled; any later eval_done is ignored in IDLE.
- abort and start in the same IDLE cycle: abort wins, stay IDLE.
- reset mid-pass: immediate return to the reset values above.
- Outputs best_*/score_sum change only in FINISH.
- All outputs are registered.

Decomposition:
- Shared package/header:
  - State encoding constants: IDLE, LOAD, ISSUE, WAIT, FINISH (3 bits).
  - Default POP_SIZE/GENE_W, so the generation controller and this block agree on population width.
- One natural sub-module: fitness_tracker, which holds run_sum and run_best with clear/update/commit controls. The FSM and the individual slice mux stay in the top.

Test Plan:
- Reset then idle: with reset asserted, all outputs 0. start held 0 for 20 cycles → busy stays 0, no eval_start.
- Full pass, POP_SIZE=4, GENE_W=8, population=0x44332211, evaluator returns score=idx*10 after 2 cycles:
  - Four eval_start pulses, with eval_indiv 0x11, 0x22, 0x33, 0x44 and eval_idx 0..3.
  - Then done for exactly 1 cycle with best_idx=3, best_score=30, score_sum=60.
- Ties and zero scores: scores 5, 9, 9, 0 → best_idx=1, best_score=9, score_sum=23. All-zero scores → best_idx=0, best_score=0, score_sum=0.
- Boundary: POP_SIZE=4, all scores 0xFFFF → score_sum=0x3FFFC with no overflow. eval_done asserted in the cycle right after eval_start is accepted.
- abort during WAIT at idx=2, coincident with eval_done:
  - Next cycle busy=0, no done; best_*/score_sum keep the prior pass.
  - A stale eval_done arriving later is ignored.
  - A following start runs a clean pass from idx 0.
- start pulsed while busy, and reset asserted mid-pass:
  - Extra start has no effect; eval_start count for the pass is POP_SIZE.
  - reset mid-pass forces IDLE and zeroes all outputs asynchronously, before the next clock edge.
